fb_write_scheduler: RTL
=======================

# fb_write_scheduler

Owns the single write port of the 640x480 framebuffer and shares it between two requesters: a built-in full-screen clear sweep and a pixel-write stream from the rasterizer. A small FSM sequences the clear (one address per cycle, 0..307199) and accepts ready/valid pixel writes only when no clear is in progress. The block converts pixel (x, y) to a linear address and drives registered `mem_we` / `mem_addr` / `mem_data` straight into the framebuffer RAM.

## Interface
Parameters:
- `DATA_WIDTH`, 1, bits per framebuffer word
- `ADDR_WIDTH`, 19, framebuffer address width
- `FB_WIDTH`, 640, pixels per line
- `FB_HEIGHT`, 480, lines per frame

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `clear_req`  in  1  single-cycle request to clear the whole framebuffer
- `clear_color`  in  DATA_WIDTH  fill value; sampled on the edge `clear_req` is accepted
- `clear_busy`  out  1  high while the sweep owns the port
- `clear_done`  out  1  one-cycle pulse on the last sweep write
- `px_valid`  in  1  pixel write request
- `px_ready`  out  1  pixel accepted when `px_valid && px_ready`
- `px_x`  in  10  pixel column
- `px_y`  in  9  pixel row
- `px_data`  in  DATA_WIDTH  pixel value
- `mem_we`  out  1  framebuffer write enable
- `mem_addr`  out  ADDR_WIDTH  framebuffer write address
- `mem_data`  out  DATA_WIDTH  framebuffer write data

## Operation
- FSM states:
  - IDLE: `px_ready`=1.
  - CLEAR: `px_ready`=0, `clear_busy`=1.
- IDLE→CLEAR on any edge with `clear_req`=1. Sweep counter loads 0 and `clear_color` is latched.
- CLEAR behaviour:
  - Each edge registers `mem_we`=1, `mem_addr`=counter, `mem_data`=latched color, then increments the counter.
  - The edge that registers address FB_WIDTH*FB_HEIGHT-1 also registers `clear_done`=1 and returns to IDLE.
  - Counter never exceeds 307199.
- Pixel handshake in IDLE: registers `mem_we`=1, `mem_addr`=y*FB_WIDTH+x (640y = (y<<9)+(y<<7), computed at ADDR_WIDTH), `mem_data`=`px_data`.
- Out-of-range pixel (x≥FB_WIDTH or y≥FB_HEIGHT): still accepted, but `mem_we`=0 (dropped).
- No handshake and not CLEAR: `mem_we`=0. `mem_addr`/`mem_data` hold their last value.
- `clear_req` while in CLEAR: ignored (no restart, no queueing).
- `clear_req` and a pixel handshake on the same IDLE edge: the pixel is written first (next cycle), then the sweep starts. The clear overwrites that pixel.
- Reset (any time, including mid-sweep): state IDLE, counter 0, sweep aborted with no `clear_done`.
- Reset values of all outputs: `mem_we`=0, `mem_addr`=0, `mem_data`=0, `clear_busy`=0, `clear_done`=0. `px_ready` is 1 once `rst_n` is high.

## Timing
- `px_ready` is decoded from the state register only; no combinational path from `px_valid` or `clear_req`.
- Pixel latency: handshake at edge k → `mem_we` high during cycle k..k+1. Throughput is 1 pixel/cycle.
- Clear latency:
  - `clear_req` at edge 0.
  - `clear_busy` high from edge 0.
  - Address 0 is registered at edge 1; address 307199 at edge 307200.
  - `clear_done` and the last `mem_we` are high in the same cycle; `clear_busy` drops and `px_ready` rises at that same edge.
- Total clear occupancy is 307200 write cycles plus 1 accept cycle.

## Configuration
- `FB_SCHED_DROP_CNT_EN` defined:
  - Adds output `drop_count` [15:0], reset 0.
  - Increments on each accepted out-of-range pixel and saturates at 16'hFFFF.
  - Cleared on `clear_req` acceptance.
- Not defined: the port does not exist, out-of-range pixels are silently dropped, and no counter logic is built.

## Structure
- Shared package `fb_pkg`:
  - `FB_WIDTH`, `FB_HEIGHT`, `FB_PIXELS` (307200), `FB_LAST_ADDR` (307199).
  - State enum `fb_sched_state_t` {IDLE, CLEAR}.
  - Coordinate widths (10/9).
- One natural sub-module: `fb_xy_to_addr` (bounds check plus shift-add address), combinational, reused by the future read-side scanout.

## Test plan
- Reset then pixel (x=5, y=2, data=1) → one cycle later `mem_we`=1, `mem_addr`=1285, `mem_data`=1.
- `clear_req` with color 0 → `clear_busy` 1, addresses 0..307199 sequential, exactly 307200 writes, `clear_done` single pulse with `mem_addr`=307199, `px_ready` high next cycle.
- `px_valid` held high during the sweep → `px_ready`=0 throughout, no pixel writes interleaved; the first pixel is written the cycle after `clear_done`.
- Simultaneous `clear_req` and pixel (x=639, y=479) in IDLE → address 307199 written, then sweep from 0; second `clear_req` mid-sweep has no effect.
- Pixel x=640, y=0 → accepted, `mem_we`=0. With `FB_SCHED_DROP_CNT_EN`, `drop_count` goes 0→1; a following `clear_req` returns it to 0.
- `rst_n` low at sweep address 1000 → all outputs reset immediately; no `clear_done`; after release `px_ready`=1 and a new clear starts at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, coordinate widths and write-scheduler
// state encoding for the 640x480 framebuffer blocks.
package fb_pkg;

    localparam int FB_WIDTH     = 640;
    localparam int FB_HEIGHT    = 480;
    localparam int FB_PIXELS    = FB_WIDTH * FB_HEIGHT;   // 307200
    localparam int FB_LAST_ADDR = FB_PIXELS - 1;          // 307199

    localparam int FB_X_W    = 10;
    localparam int FB_Y_W    = 9;
    localparam int FB_ADDR_W = 19;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_sched_state_t;

endpackage

// File: rtl/fb_xy_to_addr.sv
// fb_xy_to_addr: combinational pixel (x, y) to linear framebuffer address
// with a bounds check. Shared by the write scheduler and the read scanout.
module fb_xy_to_addr #(
    parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_W,
    parameter int FB_WIDTH   = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = fb_pkg::FB_HEIGHT
) (
    input  logic [fb_pkg::FB_X_W-1:0] x_i,
    input  logic [fb_pkg::FB_Y_W-1:0] y_i,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic                      in_range_o
);
    import fb_pkg::*;

    logic [ADDR_WIDTH-1:0] x_ext;
    logic [ADDR_WIDTH-1:0] y_ext;
    logic [ADDR_WIDTH-1:0] row_base;

    assign x_ext = ADDR_WIDTH'(x_i);
    assign y_ext = ADDR_WIDTH'(y_i);

    // 640*y is two shifts and an add; other line widths fall back to a multiply.
    generate
        if (FB_WIDTH == 640) begin : g_shift_add
            assign row_base = (y_ext << 9) + (y_ext << 7);
        end else begin : g_mult
            assign row_base = y_ext * ADDR_WIDTH'(FB_WIDTH);
        end
    endgenerate

    assign addr_o     = row_base + x_ext;
    assign in_range_o = (int'(x_i) < FB_WIDTH) && (int'(y_i) < FB_HEIGHT);

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: owns the framebuffer write port, arbitrating between a
// full-screen clear sweep and a ready/valid pixel stream. All memory-side
// outputs are registered.
// Optional feature macro: FB_SCHED_DROP_CNT_EN adds a saturating 16-bit count
// of dropped (out-of-range) pixels on output drop_count.
module fb_write_scheduler #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 19,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    input  logic [DATA_WIDTH-1:0] clear_color,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [9:0]            px_x,
    input  logic [8:0]            px_y,
    input  logic [DATA_WIDTH-1:0] px_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data
`ifdef FB_SCHED_DROP_CNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);
    import fb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);

    fb_sched_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] px_addr;
    logic                  px_in_range;
    logic                  px_fire;
    logic                  clr_accept;
    logic                  sweep_last;

    fb_xy_to_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT)
    ) u_xy_to_addr (
        .x_i        (px_x),
        .y_i        (px_y),
        .addr_o     (px_addr),
        .in_range_o (px_in_range)
    );

    assign px_fire    = px_valid && px_ready;
    assign clr_accept = (state_q == IDLE) && clear_req;
    assign sweep_last = (state_q == CLEAR) && (cnt_q == LAST_ADDR);

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter CLEAR on a request, leave after the last address.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (clear_req)  state_d = CLEAR;
            CLEAR:   if (sweep_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; no path from px_valid or clear_req.
    always_comb begin
        px_ready   = (state_q == IDLE);
        clear_busy = (state_q == CLEAR);
    end

    // Write-port next values: sweep owns the port in CLEAR, pixels in IDLE.
    always_comb begin
        cnt_d   = cnt_q;
        color_d = color_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (state_q == CLEAR) begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            data_d = color_q;
            done_d = sweep_last;
            if (!sweep_last) cnt_d = cnt_q + 1'b1;
        end else begin
            if (clr_accept) begin
                cnt_d   = '0;
                color_d = clear_color;
            end
            // A pixel accepted alongside a clear is still written first.
            if (px_fire && px_in_range) begin
                we_d   = 1'b1;
                addr_d = px_addr;
                data_d = px_data;
            end
        end
    end

    // Sweep counter, latched color and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            color_q <= color_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign clear_done = done_q;

`ifdef FB_SCHED_DROP_CNT_EN
    logic [15:0] drop_q;

    // Dropped-pixel counter: zeroed by an accepted clear, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (clr_accept) begin
            drop_q <= '0;
        end else if (px_fire && !px_in_range && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule
